// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor, planned divider).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock with a start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d, res_next;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bin_q, bin_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fs_d, fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic               ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {fs_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = minuend;
          b_d     = subtrahend;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
          amsb_d  = minuend[WIDTH-1];
          bmsb_d  = subtrahend[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next;
        bin_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = res_next;
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (amsb_q != bmsb_q) && (res_next[WIDTH-1] != amsb_q);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed boundary cases.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] minuend = '0;
  logic [W-1:0] subtrahend = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow     (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: operation timing as a countdown, results from plain integer arithmetic.
  int           m_left = 0;
  bit           m_done = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  bit           m_borrow = 0, p_borrow = 0, m_ovf = 0, p_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_diff = '0; m_borrow = 0; m_ovf = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf;
      end
    end else if (start) begin
      int ua, ub, sa, sb, sr;
      ua = int'(minuend); ub = int'(subtrahend);
      sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
      sr = sa - sb;
      p_diff   = W'((ua - ub + (1 << W)) % (1 << W));
      p_borrow = (ua < ub);
      p_ovf    = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      m_left   = W;
    end
  end

  initial begin
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      #1;
      chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("diff", {24'd0, diff}, {24'd0, m_diff});
      chk("borrow", {31'd0, borrow}, {31'd0, m_borrow});
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
    end
  end

  // Pulse start, wait bounded for done, then pin the result to hand-given values.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input bit noisy,
                        input string nm);
    int cyc;
    bit got;
    @(negedge clk);
    minuend = a; subtrahend = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) begin got = 1; break; end
      if (busy) cyc++;
      if (noisy && busy) begin
        start = 1'($urandom_range(0, 1));
        minuend = W'($urandom); subtrahend = W'($urandom);
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, " done_seen"}, {31'd0, got}, 32'd1);
    chk({nm, " busy_cycles"}, cyc, W);
    chk({nm, " diff"}, {24'd0, diff}, {24'd0, ed});
    chk({nm, " borrow"}, {31'd0, borrow}, {31'd0, eb});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset diff", {24'd0, diff}, 32'd0);
    chk("reset borrow", {31'd0, borrow}, 32'd0);

    run_op(8'd100, 8'd37, 8'd63, 1'b0, 0, "basic");
    run_op(8'd5, 8'd9, 8'hFC, 1'b1, 0, "borrow");
    repeat (20) @(negedge clk);
    #1;
    chk("hold diff", {24'd0, diff}, 32'hFC);
    chk("hold borrow", {31'd0, borrow}, 32'd1);

    run_op(8'h00, 8'h00, 8'h00, 1'b0, 0, "zero_zero");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 0, "zero_ff");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 0, "ff_ff");

    // Start during SHIFT must be ignored.
    @(negedge clk);
    minuend = 8'd100; subtrahend = 8'd37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    minuend = 8'd1; subtrahend = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ignore diff", {24'd0, diff}, 32'd63);
      end
    end
    chk("ignore done_count", ndone, 1);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    minuend = 8'd77; subtrahend = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst diff", {24'd0, diff}, 32'd0);
    chk("midrst borrow", {31'd0, borrow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd200, 8'd55, 8'd145, 1'b0, 0, "after_rst");

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 0, "ovf_pos");
    chk("ovf_pos ovf", {31'd0, ovf}, 32'd1);
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 0, "ovf_neg");
    chk("ovf_neg ovf", {31'd0, ovf}, 32'd0);
`endif

    for (int k = 0; k < 200; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, ra - rb, ra < rb, (k % 3) == 0, "rand");
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
